load_store_unit: RTL and testbench



---
 rtl/load_store_unit_if.sv | 35 +++
 rtl/load_store_unit.sv | 190 +++++++++++++++++++
 tb/tb_load_store_unit.sv | 252 +++++++++++++++++++++++++
 3 files changed

// File: rtl/load_store_unit_if.sv
// Request/response and memory-controller signal bundle for load_store_unit.
// The unit attaches via the slave modport; the CPU side and memory model use master.
interface load_store_unit_if;
    logic        req_valid;
    logic        req_ready;
    logic        req_write;
    logic [1:0]  req_size;
    logic        req_signed;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic        rsp_fault;
    logic [1:0]  rsp_fault_code;
    logic        mem_read;
    logic        mem_write;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
    logic        mem_error;

    modport slave (
        input  req_valid, req_write, req_size, req_signed, req_addr, req_wdata,
        input  mem_rdata, mem_error,
        output req_ready, rsp_valid, rsp_rdata, rsp_fault, rsp_fault_code,
        output mem_read, mem_write, mem_addr, mem_wdata
    );

    modport master (
        output req_valid, req_write, req_size, req_signed, req_addr, req_wdata,
        output mem_rdata, mem_error,
        input  req_ready, rsp_valid, rsp_rdata, rsp_fault, rsp_fault_code,
        input  mem_read, mem_write, mem_addr, mem_wdata
    );
endinterface

// File: rtl/load_store_unit.sv
// Load/store sequencer: size/alignment checks, read-modify-write for sub-word
// stores, load lane extraction with sign/zero extension, one response per request.
module load_store_unit #(
    parameter int unsigned RD_LATENCY = 2
) (
    input  logic               clk,
    input  logic               rst,
    load_store_unit_if.slave   bus
);
    typedef enum logic [1:0] {S_IDLE, S_READ, S_WRITE, S_RESP} state_e;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;
    localparam logic [1:0] SZ_BAD  = 2'b11;

    localparam logic [1:0] FC_MISALIGN = 2'b01;
    localparam logic [1:0] FC_BUS      = 2'b10;
    localparam logic [1:0] FC_SIZE     = 2'b11;

    state_e      state_q;
    logic [3:0]  cnt_q;
    logic        req_ready_q;
    logic        rsp_valid_q;
    logic [31:0] rsp_rdata_q;
    logic        rsp_fault_q;
    logic [1:0]  rsp_code_q;
    logic        mem_read_q;
    logic        mem_write_q;
    logic [31:0] mem_addr_q;
    logic [31:0] mem_wdata_q;

    logic        wr_q;
    logic [1:0]  size_q;
    logic        signed_q;
    logic [1:0]  lane_q;
    logic [31:0] wdata_q;

    logic        accept;
    logic        misaligned_d;
    logic [7:0]  byte_sel;
    logic [15:0] half_sel;
    logic [31:0] load_data_d;
    logic [31:0] merged_d;

    assign accept       = (state_q == S_IDLE) && req_ready_q && bus.req_valid;
    assign misaligned_d = ((bus.req_size == SZ_HALF) && bus.req_addr[0]) ||
                          ((bus.req_size == SZ_WORD) && (bus.req_addr[1:0] != 2'b00));

    // NOTE: combinational block assigns every output first so no latch is inferred.
    always_comb begin
        byte_sel    = bus.mem_rdata[7:0];
        half_sel    = lane_q[1] ? bus.mem_rdata[31:16] : bus.mem_rdata[15:0];
        load_data_d = bus.mem_rdata;
        merged_d    = wdata_q;
        case (lane_q)
            2'd1:    byte_sel = bus.mem_rdata[15:8];
            2'd2:    byte_sel = bus.mem_rdata[23:16];
            2'd3:    byte_sel = bus.mem_rdata[31:24];
            default: byte_sel = bus.mem_rdata[7:0];
        endcase
        case (size_q)
            SZ_BYTE: begin
                load_data_d = {{24{signed_q & byte_sel[7]}}, byte_sel};
                case (lane_q)
                    2'd0:    merged_d = {bus.mem_rdata[31:8], wdata_q[7:0]};
                    2'd1:    merged_d = {bus.mem_rdata[31:16], wdata_q[7:0], bus.mem_rdata[7:0]};
                    2'd2:    merged_d = {bus.mem_rdata[31:24], wdata_q[7:0], bus.mem_rdata[15:0]};
                    default: merged_d = {wdata_q[7:0], bus.mem_rdata[23:0]};
                endcase
            end
            SZ_HALF: begin
                load_data_d = {{16{signed_q & half_sel[15]}}, half_sel};
                merged_d    = lane_q[1] ? {wdata_q[15:0], bus.mem_rdata[15:0]}
                                        : {bus.mem_rdata[31:16], wdata_q[15:0]};
            end
            default: begin
                load_data_d = bus.mem_rdata;
                merged_d    = wdata_q;
            end
        endcase
    end

    // NOTE: request fields are only read after being loaded on accept, so they need no reset.
    always_ff @(posedge clk) begin
        if (accept) begin
            wr_q     <= bus.req_write;
            size_q   <= bus.req_size;
            signed_q <= bus.req_signed;
            lane_q   <= bus.req_addr[1:0];
            wdata_q  <= bus.req_wdata;
        end
    end

    // NOTE: sequential state uses non-blocking assignments; reset wins over any transition.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            req_ready_q <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= '0;
            rsp_fault_q <= 1'b0;
            rsp_code_q  <= '0;
            mem_read_q  <= 1'b0;
            mem_write_q <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
        end else begin
            rsp_valid_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    req_ready_q <= 1'b1;
                    if (accept) begin
                        req_ready_q <= 1'b0;
                        if (bus.req_size == SZ_BAD) begin
                            rsp_valid_q <= 1'b1;
                            rsp_fault_q <= 1'b1;
                            rsp_code_q  <= FC_SIZE;
                            state_q     <= S_RESP;
                        end else if (misaligned_d) begin
                            rsp_valid_q <= 1'b1;
                            rsp_fault_q <= 1'b1;
                            rsp_code_q  <= FC_MISALIGN;
                            state_q     <= S_RESP;
                        end else begin
                            mem_addr_q <= {bus.req_addr[31:2], 2'b00};
                            if (bus.req_write && (bus.req_size == SZ_WORD)) begin
                                mem_wdata_q <= bus.req_wdata;
                                mem_write_q <= 1'b1;
                                state_q     <= S_WRITE;
                            end else begin
                                mem_read_q <= 1'b1;
                                cnt_q      <= 4'(RD_LATENCY - 1);
                                state_q    <= S_READ;
                            end
                        end
                    end
                end
                S_READ: begin
                    if (cnt_q != 4'd0) begin
                        cnt_q <= cnt_q - 4'd1;
                    end else begin
                        mem_read_q <= 1'b0;
                        if (bus.mem_error) begin
                            rsp_valid_q <= 1'b1;
                            rsp_fault_q <= 1'b1;
                            rsp_code_q  <= FC_BUS;
                            state_q     <= S_RESP;
                        end else if (!wr_q) begin
                            rsp_valid_q <= 1'b1;
                            rsp_rdata_q <= load_data_d;
                            state_q     <= S_RESP;
                        end else begin
                            mem_wdata_q <= merged_d;
                            mem_write_q <= 1'b1;
                            state_q     <= S_WRITE;
                        end
                    end
                end
                S_WRITE: begin
                    mem_write_q <= 1'b0;
                    rsp_valid_q <= 1'b1;
                    if (bus.mem_error) begin
                        rsp_fault_q <= 1'b1;
                        rsp_code_q  <= FC_BUS;
                    end
                    state_q <= S_RESP;
                end
                default: begin
                    req_ready_q <= 1'b1;
                    rsp_rdata_q <= '0;
                    rsp_fault_q <= 1'b0;
                    rsp_code_q  <= '0;
                    state_q     <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.req_ready      = req_ready_q;
    assign bus.rsp_valid      = rsp_valid_q;
    assign bus.rsp_rdata      = rsp_rdata_q;
    assign bus.rsp_fault      = rsp_fault_q;
    assign bus.rsp_fault_code = rsp_code_q;
    assign bus.mem_read       = mem_read_q;
    assign bus.mem_write      = mem_write_q;
    assign bus.mem_addr       = mem_addr_q;
    assign bus.mem_wdata      = mem_wdata_q;
endmodule

// File: tb/tb_load_store_unit.sv
// Scoreboard bench for load_store_unit with a word-addressed memory model behind
// the controller port; responses and writes are checked against queued expectations.
module tb_load_store_unit;
    localparam int L = 2;

    typedef struct {
        logic [31:0] rdata;
        logic [1:0]  code;
        int          t_acc;
        int          lat;
    } rsp_t;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] data;
    } wr_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic err_inject = 1'b0;
    int   cyc = 0;
    int   checks = 0;
    int   failures = 0;
    int   rd_cycles = 0;
    int   wr_cycles = 0;
    int   both_strobes = 0;
    int   addr_unstable = 0;
    logic        prev_strobe = 1'b0;
    logic [31:0] prev_addr = '0;
    logic [31:0] mem [0:1023];
    rsp_t sb[$];
    wr_t  wq[$];

    load_store_unit_if bus ();

    load_store_unit #(.RD_LATENCY(L)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(posedge clk) begin
        if (bus.mem_write === 1'b1) mem[bus.mem_addr[11:2]] <= bus.mem_wdata;
    end

    assign bus.mem_rdata = mem[bus.mem_addr[11:2]];
    assign bus.mem_error = err_inject;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    always @(negedge clk) begin
        if (bus.mem_read === 1'b1 && bus.mem_write === 1'b1) both_strobes++;
        if (bus.mem_read === 1'b1) rd_cycles++;
        if ((bus.mem_read === 1'b1 || bus.mem_write === 1'b1) && prev_strobe &&
            bus.mem_addr !== prev_addr) addr_unstable++;
        prev_strobe = (bus.mem_read === 1'b1) || (bus.mem_write === 1'b1);
        prev_addr   = bus.mem_addr;
        if (bus.mem_write === 1'b1) begin
            wr_cycles++;
            if (wq.size() != 0) begin
                wr_t w;
                w = wq.pop_front();
                check("wr_addr", bus.mem_addr, w.addr);
                check("wr_data", bus.mem_wdata, w.data);
            end else begin
                check("unexpected_write", 32'(bus.mem_write), 32'd0);
            end
        end
        if (bus.rsp_valid === 1'b1) begin
            if (sb.size() != 0) begin
                rsp_t e;
                e = sb.pop_front();
                check("rsp_rdata", bus.rsp_rdata, e.rdata);
                check("rsp_code", 32'(bus.rsp_fault_code), 32'(e.code));
                check("rsp_fault", 32'(bus.rsp_fault), 32'(e.code != 2'b00));
                check("rsp_latency", 32'(cyc - e.t_acc), 32'(e.lat));
            end else begin
                check("unexpected_rsp", 32'(bus.rsp_valid), 32'd0);
            end
        end
    end

    task automatic wait_ready();
        int guard = 0;
        @(negedge clk);
        while (bus.req_ready !== 1'b1 && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        if (bus.req_ready !== 1'b1) check("ready_timeout", 32'(bus.req_ready), 32'd1);
    endtask

    task automatic issue(input logic wr, input logic [1:0] sz, input logic sg,
                         input logic [31:0] addr, input logic [31:0] wdata,
                         input logic [31:0] exp_rdata, input logic [1:0] exp_code,
                         input int exp_lat, input logic exp_wr, input logic [31:0] exp_wdata);
        int guard = 0;
        rsp_t e;
        wr_t  w;
        wait_ready();
        bus.req_valid  = 1'b1;
        bus.req_write  = wr;
        bus.req_size   = sz;
        bus.req_signed = sg;
        bus.req_addr   = addr;
        bus.req_wdata  = wdata;
        e.rdata = exp_rdata;
        e.code  = exp_code;
        e.t_acc = cyc;
        e.lat   = exp_lat;
        sb.push_back(e);
        if (exp_wr) begin
            w.addr = {addr[31:2], 2'b00};
            w.data = exp_wdata;
            wq.push_back(w);
        end
        @(negedge clk);
        bus.req_valid = 1'b0;
        while (sb.size() != 0 && guard < 100) begin
            @(negedge clk);
            guard++;
        end
        if (sb.size() != 0) begin
            check("rsp_timeout", 32'(sb.size()), 32'd0);
            sb.delete();
        end
        if (wq.size() != 0) begin
            check("write_missing", 32'(wq.size()), 32'd0);
            wq.delete();
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_req_ready"}, 32'(bus.req_ready), 32'd0);
        check({tag, "_rsp_valid"}, 32'(bus.rsp_valid), 32'd0);
        check({tag, "_rsp_rdata"}, bus.rsp_rdata, 32'd0);
        check({tag, "_rsp_fault"}, 32'(bus.rsp_fault), 32'd0);
        check({tag, "_rsp_code"}, 32'(bus.rsp_fault_code), 32'd0);
        check({tag, "_mem_read"}, 32'(bus.mem_read), 32'd0);
        check({tag, "_mem_write"}, 32'(bus.mem_write), 32'd0);
        check({tag, "_mem_addr"}, bus.mem_addr, 32'd0);
        check({tag, "_mem_wdata"}, bus.mem_wdata, 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int rd0;
        int wr0;
        bus.req_valid  = 1'b0;
        bus.req_write  = 1'b0;
        bus.req_size   = 2'b00;
        bus.req_signed = 1'b0;
        bus.req_addr   = '0;
        bus.req_wdata  = '0;

        repeat (3) @(negedge clk);
        check_reset_outputs("reset");
        rst = 1'b0;
        @(negedge clk);
        check("ready_after_reset", 32'(bus.req_ready), 32'd1);

        // Word store then word load at 0x100.
        issue(1'b1, 2'b10, 1'b0, 32'h100, 32'hDEAD_BEEF, 32'h0, 2'b00, 2, 1'b1, 32'hDEAD_BEEF);
        issue(1'b0, 2'b10, 1'b0, 32'h100, 32'h0, 32'hDEAD_BEEF, 2'b00, L + 1, 1'b0, 32'h0);

        // Byte and half read-modify-write at 0x200; upper wdata bits must be ignored.
        issue(1'b1, 2'b10, 1'b0, 32'h200, 32'h1122_3344, 32'h0, 2'b00, 2, 1'b1, 32'h1122_3344);
        issue(1'b1, 2'b00, 1'b0, 32'h201, 32'hCCCC_CCAB, 32'h0, 2'b00, L + 2, 1'b1, 32'h1122_AB44);
        issue(1'b0, 2'b10, 1'b0, 32'h200, 32'h0, 32'h1122_AB44, 2'b00, L + 1, 1'b0, 32'h0);
        issue(1'b1, 2'b01, 1'b0, 32'h202, 32'hFFFF_1234, 32'h0, 2'b00, L + 2, 1'b1, 32'h1234_AB44);

        // Extraction and extension from 0x80FF7F01 at 0x300.
        issue(1'b1, 2'b10, 1'b0, 32'h300, 32'h80FF_7F01, 32'h0, 2'b00, 2, 1'b1, 32'h80FF_7F01);
        issue(1'b0, 2'b00, 1'b1, 32'h302, 32'h0, 32'hFFFF_FFFF, 2'b00, L + 1, 1'b0, 32'h0);
        issue(1'b0, 2'b00, 1'b0, 32'h300, 32'h0, 32'h0000_0001, 2'b00, L + 1, 1'b0, 32'h0);
        issue(1'b0, 2'b01, 1'b1, 32'h302, 32'h0, 32'hFFFF_80FF, 2'b00, L + 1, 1'b0, 32'h0);
        issue(1'b0, 2'b01, 1'b0, 32'h302, 32'h0, 32'h0000_80FF, 2'b00, L + 1, 1'b0, 32'h0);
        issue(1'b0, 2'b01, 1'b1, 32'h300, 32'h0, 32'h0000_7F01, 2'b00, L + 1, 1'b0, 32'h0);
        issue(1'b0, 2'b00, 1'b1, 32'h301, 32'h0, 32'h0000_007F, 2'b00, L + 1, 1'b0, 32'h0);
        issue(1'b0, 2'b00, 1'b0, 32'h303, 32'h0, 32'h0000_0080, 2'b00, L + 1, 1'b0, 32'h0);
        issue(1'b0, 2'b00, 1'b1, 32'h303, 32'h0, 32'hFFFF_FF80, 2'b00, L + 1, 1'b0, 32'h0);

        // Size and alignment faults issue no bus access at all.
        rd0 = rd_cycles;
        wr0 = wr_cycles;
        issue(1'b0, 2'b01, 1'b0, 32'h401, 32'h0, 32'h0, 2'b01, 1, 1'b0, 32'h0);
        issue(1'b1, 2'b10, 1'b0, 32'h402, 32'h5555_5555, 32'h0, 2'b01, 1, 1'b0, 32'h0);
        issue(1'b1, 2'b11, 1'b0, 32'h400, 32'h5555_5555, 32'h0, 2'b11, 1, 1'b0, 32'h0);
        issue(1'b0, 2'b11, 1'b1, 32'h404, 32'h0, 32'h0, 2'b11, 1, 1'b0, 32'h0);
        check("fault_no_read", 32'(rd_cycles - rd0), 32'd0);
        check("fault_no_write", 32'(wr_cycles - wr0), 32'd0);

        // Bus error on the read sample: no write, rdata 0.
        wr0 = wr_cycles;
        err_inject = 1'b1;
        issue(1'b1, 2'b00, 1'b0, 32'h200, 32'h0000_00EE, 32'h0, 2'b10, L + 1, 1'b0, 32'h0);
        issue(1'b0, 2'b10, 1'b0, 32'h300, 32'h0, 32'h0, 2'b10, L + 1, 1'b0, 32'h0);
        issue(1'b1, 2'b10, 1'b0, 32'h304, 32'h0BAD_0BAD, 32'h0, 2'b10, 2, 1'b1, 32'h0BAD_0BAD);
        err_inject = 1'b0;
        check("buserr_write_count", 32'(wr_cycles - wr0), 32'd1);

        // Top-of-memory word access.
        issue(1'b1, 2'b10, 1'b0, 32'hFFFF_FFFC, 32'hA5A5_5A5A, 32'h0, 2'b00, 2, 1'b1, 32'hA5A5_5A5A);
        issue(1'b0, 2'b10, 1'b0, 32'hFFFF_FFFC, 32'h0, 32'hA5A5_5A5A, 2'b00, L + 1, 1'b0, 32'h0);

        // Reset during the second READ cycle of a byte store.
        wait_ready();
        wr0 = wr_cycles;
        bus.req_valid  = 1'b1;
        bus.req_write  = 1'b1;
        bus.req_size   = 2'b00;
        bus.req_signed = 1'b0;
        bus.req_addr   = 32'h200;
        bus.req_wdata  = 32'h0000_0077;
        @(negedge clk);
        bus.req_valid = 1'b0;
        @(negedge clk);
        check("read_before_rst", 32'(bus.mem_read), 32'd1);
        rst = 1'b1;
        @(negedge clk);
        check_reset_outputs("midrst");
        rst = 1'b0;
        @(negedge clk);
        check("ready_after_midrst", 32'(bus.req_ready), 32'd1);
        repeat (4) @(negedge clk);
        check("midrst_no_write", 32'(wr_cycles - wr0), 32'd0);
        issue(1'b0, 2'b10, 1'b0, 32'h200, 32'h0, 32'h1234_AB44, 2'b00, L + 1, 1'b0, 32'h0);

        repeat (3) @(negedge clk);
        check("strobe_exclusive", 32'(both_strobes), 32'd0);
        check("addr_stable", 32'(addr_unstable), 32'd0);
        check("scoreboard_drained", 32'(sb.size() + wq.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
